pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter unit for the LEGv8 pipeline.
- Owns the PC register and consumes the 2-bit `PCSrc` produced by the EX-stage branch control.
- Selects the next fetch address and raises the flush signals for wrong-path instructions.
- Tracks halt (`PCSrc` = 11) and misaligned-target fault states.
- Keeps a saturating taken-redirect counter for performance monitoring.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, PC and target width.
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `CNT_WIDTH`, 32, taken-redirect counter width.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `PCSrc`  input  2  from branch control: 00 = PC+4, 01 = branch target, 10 = ALU/register target, 11 = no increment (halt).
- `ex_valid`  input  1  EX-stage instruction is valid; `PCSrc` is ignored when low.
- `BrTarget`  input  ADDR_WIDTH  PC-relative target computed in EX.
- `AluTarget`  input  ADDR_WIDTH  register target (BR) from ALU.
- `Stall`  input  1  hazard-unit stall: hold PC.
- `resume`  input  1  leave HALT.
- `PC`  output  ADDR_WIDTH  current fetch address (registered).
- `PCPlus4`  output  ADDR_WIDTH  PC + 4, combinational, modulo 2^ADDR_WIDTH.
- `Flush_IFID`  output  1  combinational; kill the IF/ID instruction.
- `Flush_IDEX`  output  1  combinational; kill the ID/EX instruction.
- `fetch_en`  output  1  registered; instruction memory read enable.
- `fault`  output  1  registered, sticky misaligned-target flag.
- `br_taken_cnt`  output  CNT_WIDTH  registered count of taken redirects.

## Operation
- A taken redirect (`take`) is `ex_valid` high, `PCSrc` = 01 or 10, and state RUN.
- The selected target is `BrTarget` for 01 and `AluTarget` for 10.
- `misalign` is `take` with target[1:0] ≠ 0.

States: RUN, HALT, FAULT.
- **RUN**, in priority order:
  - `misalign`: go to FAULT, set `fault`=1, PC holds, flushes asserted.
  - `take`: PC ← target, `Flush_IFID`=`Flush_IDEX`=1, counter +1.
  - `ex_valid` high and `PCSrc`=11: go to HALT, PC holds, `Flush_IFID`=1, `Flush_IDEX`=1.
  - `Stall`: PC holds.
  - Otherwise: PC ← PC+4.
- A redirect overrides `Stall`. The stalled instruction is on the wrong path and is flushed.
- **HALT**: PC holds, `fetch_en`=0, no flushes.
  - `resume` high: next state RUN with `fetch_en`=1 and PC unchanged.
  - `PCSrc` is ignored.
- **FAULT**: PC holds, `fetch_en`=0. Only `rst` exits.
- `ex_valid` low: `PCSrc` is treated as 00.
- The counter saturates at all ones. It counts only `take` without `misalign`.
- PC+4 wraps modulo 2^ADDR_WIDTH with no fault.

## Timing
Reset values (`rst` high at an edge):
- PC=`RESET_PC`, state RUN, `fetch_en`=1, `fault`=0, `br_taken_cnt`=0.
- Flush outputs are forced 0 while `rst` is high.

Reset mid-operation (HALT, FAULT, or a redirect in the same cycle): reset wins and all state is as above at the next edge.

Latency:
- `PCSrc` sampled in cycle N gives the new PC visible in cycle N+1.
- Flushes are asserted in cycle N, combinationally from `take`/halt, so the IF/ID and ID/EX registers clear at the edge ending cycle N.
- The state and `fetch_en` change at the same edge.
- `br_taken_cnt` reflects the redirect in cycle N+1.

Back-to-back redirects in consecutive cycles each take effect. The second redirect's target wins in the cycle after it.

## Test plan
- **Reset and sequential fetch:** reset with `RESET_PC`=0, then 3 idle cycles → PC = 0, 4, 8, 12; `fetch_en`=1; flushes 0.
- **Branch taken:** PC=0x100, `ex_valid`=1, `PCSrc`=01, `BrTarget`=0x40 → flushes high that cycle; next PC=0x40; `br_taken_cnt`=1.
- **Stall vs. redirect:**
  - `Stall`=1 with `PCSrc`=10, `AluTarget`=0x200 → next PC=0x200.
  - `Stall`=1 alone → PC held for 3 cycles.
  - `PCSrc`=01 with `ex_valid`=0 → no redirect.
- **Halt/resume:** `PCSrc`=11 at PC=0x20 → `fetch_en`=0 and PC=0x20 for 5 cycles, even with `PCSrc`=01 applied. `resume`=1 → `fetch_en`=1, PC=0x20, then 0x24.
- **Misaligned target:** `PCSrc`=01, `BrTarget`=0x42 → `fault`=1, PC unchanged, `fetch_en`=0, counter unchanged. `resume` has no effect; only `rst` clears.
- **Saturation/wrap:**
  - `CNT_WIDTH`=2, 5 taken branches → counter stops at 3.
  - PC=0xFFFF_FFFF_FFFF_FFFC with no branch → next PC=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: owns the PC, picks the next fetch address from PCSrc,
// raises wrong-path flushes, tracks HALT/FAULT and counts taken redirects.
module pc_unit #(
    parameter int unsigned                  ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]        RESET_PC   = '0,
    parameter int unsigned                  CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            PCSrc,
    input  logic                  ex_valid,
    input  logic [ADDR_WIDTH-1:0] BrTarget,
    input  logic [ADDR_WIDTH-1:0] AluTarget,
    input  logic                  Stall,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] PCPlus4,
    output logic                  Flush_IFID,
    output logic                  Flush_IDEX,
    output logic                  fetch_en,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  br_taken_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HALT  = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] target;
    logic                  take;
    logic                  misalign;
    logic                  halt_req;
    logic                  flush;
    logic                  cnt_inc;

    assign PCPlus4  = PC + ADDR_WIDTH'(4);
    assign target   = (PCSrc == 2'b01) ? BrTarget : AluTarget;
    assign take     = ex_valid && (state == RUN) && ((PCSrc == 2'b01) || (PCSrc == 2'b10));
    assign misalign = take && (target[1:0] != 2'b00);
    assign halt_req = ex_valid && (state == RUN) && (PCSrc == 2'b11);

    always_comb begin
        state_next = state;
        pc_next    = PC;
        flush      = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            RUN: begin
                // Redirects are checked before Stall: the stalled instruction is wrong-path.
                if (misalign) begin
                    state_next = FAULT;
                    flush      = 1'b1;
                end else if (take) begin
                    pc_next = target;
                    flush   = 1'b1;
                    cnt_inc = 1'b1;
                end else if (halt_req) begin
                    state_next = HALT;
                    flush      = 1'b1;
                end else if (!Stall) begin
                    pc_next = PCPlus4;
                end
            end
            HALT: begin
                if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    assign Flush_IFID = flush && !rst;
    assign Flush_IDEX = flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            PC           <= RESET_PC;
            state        <= RUN;
            fetch_en     <= 1'b1;
            fault        <= 1'b0;
            br_taken_cnt <= '0;
        end else begin
            PC       <= pc_next;
            state    <= state_next;
            fetch_en <= (state_next == RUN);
            if (state_next == FAULT) begin
                fault <= 1'b1;
            end
            if (cnt_inc && (br_taken_cnt != '1)) begin
                br_taken_cnt <= br_taken_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit plus a saturation sequence on a
// narrow-counter instance.
module tb_pc_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ex_valid, Stall, resume;
    logic [1:0]  PCSrc;
    logic [63:0] BrTarget, AluTarget;
    logic [63:0] PC, PCPlus4;
    logic        Flush_IFID, Flush_IDEX, fetch_en, fault;
    logic [31:0] br_taken_cnt;

    logic        s_rst, s_ex_valid;
    logic [1:0]  s_PCSrc;
    logic [63:0] s_BrTarget;
    logic [63:0] s_PC, s_PCPlus4;
    logic        s_Flush_IFID, s_Flush_IDEX, s_fetch_en, s_fault;
    logic [1:0]  s_cnt;

    pc_unit #(.ADDR_WIDTH(64), .RESET_PC(64'h0), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .ex_valid(ex_valid),
        .BrTarget(BrTarget), .AluTarget(AluTarget), .Stall(Stall), .resume(resume),
        .PC(PC), .PCPlus4(PCPlus4), .Flush_IFID(Flush_IFID), .Flush_IDEX(Flush_IDEX),
        .fetch_en(fetch_en), .fault(fault), .br_taken_cnt(br_taken_cnt)
    );

    pc_unit #(.ADDR_WIDTH(64), .RESET_PC(64'h0), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(s_rst), .PCSrc(s_PCSrc), .ex_valid(s_ex_valid),
        .BrTarget(s_BrTarget), .AluTarget(64'h0), .Stall(1'b0), .resume(1'b0),
        .PC(s_PC), .PCPlus4(s_PCPlus4), .Flush_IFID(s_Flush_IFID), .Flush_IDEX(s_Flush_IDEX),
        .fetch_en(s_fetch_en), .fault(s_fault), .br_taken_cnt(s_cnt)
    );

    typedef struct {
        string       name;
        logic        rst, ev;
        logic [1:0]  src;
        logic [63:0] br, alu;
        logic        stall, resume;
        logic        fl;
        logic [63:0] pc;
        logic        fe, flt;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic ev,
                                input logic [1:0] src, input logic [63:0] br,
                                input logic [63:0] alu, input logic st, input logic rs,
                                input logic fl, input logic [63:0] pc, input logic fe,
                                input logic flt, input logic [31:0] cnt);
        vec_t v;
        v.name = name; v.rst = r; v.ev = ev; v.src = src; v.br = br; v.alu = alu;
        v.stall = st; v.resume = rs; v.fl = fl; v.pc = pc; v.fe = fe; v.flt = flt; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        //                   name           rst ev src    br      alu   st rs  fl  pc     fe flt cnt
        vecs.push_back(mk("reset_redir",    1, 1, 2'b01, 64'h40, 64'h0, 0, 0,  0, 64'h0,  1, 0, 0));
        vecs.push_back(mk("seq0",           0, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'h4,  1, 0, 0));
        vecs.push_back(mk("seq1",           0, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'h8,  1, 0, 0));
        vecs.push_back(mk("seq2",           0, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'hc,  1, 0, 0));
        vecs.push_back(mk("to_100",         0, 1, 2'b10, 64'h0,  64'h100,0,0,  1, 64'h100,1, 0, 1));
        vecs.push_back(mk("br_40",          0, 1, 2'b01, 64'h40, 64'h0, 0, 0,  1, 64'h40, 1, 0, 2));
        vecs.push_back(mk("stall_redir",    0, 1, 2'b10, 64'h0,  64'h200,1,0,  1, 64'h200,1, 0, 3));
        vecs.push_back(mk("stall0",         0, 0, 2'b00, 64'h0,  64'h0, 1, 0,  0, 64'h200,1, 0, 3));
        vecs.push_back(mk("stall1",         0, 0, 2'b00, 64'h0,  64'h0, 1, 0,  0, 64'h200,1, 0, 3));
        vecs.push_back(mk("stall2",         0, 0, 2'b00, 64'h0,  64'h0, 1, 0,  0, 64'h200,1, 0, 3));
        vecs.push_back(mk("invalid_br",     0, 0, 2'b01, 64'h40, 64'h0, 0, 0,  0, 64'h204,1, 0, 3));
        vecs.push_back(mk("b2b_first",      0, 1, 2'b01, 64'h300,64'h0, 0, 0,  1, 64'h300,1, 0, 4));
        vecs.push_back(mk("b2b_second",     0, 1, 2'b10, 64'h0,  64'h80,0, 0,  1, 64'h80, 1, 0, 5));
        vecs.push_back(mk("br_20",          0, 1, 2'b01, 64'h20, 64'h0, 0, 0,  1, 64'h20, 1, 0, 6));
        vecs.push_back(mk("halt",           0, 1, 2'b11, 64'h0,  64'h0, 0, 0,  1, 64'h20, 0, 0, 6));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("halt_hold",  0, 1, 2'b01, 64'h40, 64'h0, 0, 0,  0, 64'h20, 0, 0, 6));
        vecs.push_back(mk("resume",         0, 0, 2'b00, 64'h0,  64'h0, 0, 1,  0, 64'h20, 1, 0, 6));
        vecs.push_back(mk("after_resume",   0, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'h24, 1, 0, 6));
        vecs.push_back(mk("invalid_halt",   0, 0, 2'b11, 64'h0,  64'h0, 0, 0,  0, 64'h28, 1, 0, 6));
        vecs.push_back(mk("misalign",       0, 1, 2'b01, 64'h42, 64'h0, 0, 0,  1, 64'h28, 0, 1, 6));
        vecs.push_back(mk("fault_resume",   0, 0, 2'b00, 64'h0,  64'h0, 0, 1,  0, 64'h28, 0, 1, 6));
        vecs.push_back(mk("fault_redir",    0, 1, 2'b10, 64'h0,  64'h100,0,0,  0, 64'h28, 0, 1, 6));
        vecs.push_back(mk("fault_rst",      1, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'h0,  1, 0, 0));
        vecs.push_back(mk("to_top",         0, 1, 2'b10, 64'h0,  64'hffff_ffff_ffff_fffc,0,0, 1, 64'hffff_ffff_ffff_fffc, 1, 0, 1));
        vecs.push_back(mk("wrap",           0, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'h0,  1, 0, 1));
        vecs.push_back(mk("misalign_alu",   0, 1, 2'b10, 64'h0,  64'h101,0,0,  1, 64'h0,  0, 1, 1));
        vecs.push_back(mk("rst2",           1, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'h0,  1, 0, 0));
        vecs.push_back(mk("seq3",           0, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'h4,  1, 0, 0));
        vecs.push_back(mk("halt2",          0, 1, 2'b11, 64'h0,  64'h0, 0, 0,  1, 64'h4,  0, 0, 0));
        vecs.push_back(mk("halt_rst",       1, 0, 2'b00, 64'h0,  64'h0, 0, 0,  0, 64'h0,  1, 0, 0));

        rst = 1'b1; ex_valid = 1'b0; PCSrc = 2'b00; BrTarget = '0; AluTarget = '0;
        Stall = 1'b0; resume = 1'b0;
        s_rst = 1'b1; s_ex_valid = 1'b0; s_PCSrc = 2'b00; s_BrTarget = '0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; ex_valid = vecs[i].ev; PCSrc = vecs[i].src;
            BrTarget = vecs[i].br; AluTarget = vecs[i].alu;
            Stall = vecs[i].stall; resume = vecs[i].resume;
            #1;
            chk({vecs[i].name, ".flush_ifid"}, 64'(Flush_IFID), 64'(vecs[i].fl));
            chk({vecs[i].name, ".flush_idex"}, 64'(Flush_IDEX), 64'(vecs[i].fl));
            @(posedge clk); #1;
            chk({vecs[i].name, ".pc"},       PC,                 vecs[i].pc);
            chk({vecs[i].name, ".pcplus4"},  PCPlus4,            vecs[i].pc + 64'd4);
            chk({vecs[i].name, ".fetch_en"}, 64'(fetch_en),      64'(vecs[i].fe));
            chk({vecs[i].name, ".fault"},    64'(fault),         64'(vecs[i].flt));
            chk({vecs[i].name, ".cnt"},      64'(br_taken_cnt),  64'(vecs[i].cnt));
        end

        // Saturating 2-bit counter: five taken branches stop the count at 3.
        s_rst = 1'b1;
        @(posedge clk); #1;
        chk("sat.reset_cnt", 64'(s_cnt), 64'd0);
        s_rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            s_ex_valid = 1'b1; s_PCSrc = 2'b01; s_BrTarget = 64'(i * 16);
            @(posedge clk); #1;
            chk($sformatf("sat.cnt%0d", i), 64'(s_cnt), (i < 3) ? 64'(i) : 64'd3);
            chk($sformatf("sat.pc%0d", i),  s_PC,       64'(i * 16));
        end
        s_ex_valid = 1'b0; s_PCSrc = 2'b00;
        @(posedge clk); #1;
        chk("sat.hold", 64'(s_cnt), 64'd3);
        s_rst = 1'b1;
        @(posedge clk); #1;
        chk("sat.clear", 64'(s_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
